// File: rtl/newton_recip_if.sv
// ---------------------------------------------------------------------------
// newton_recip_if -- request/result bundle for the newton_recip reciprocal unit.
//
// Signals:
//   start     : request pulse, sampled only while the unit is idle
//   d_in      : divisor, U1.15, normalized to [1.0, 2.0)
//   lut_idx   : seed-table index (captured divisor bits [14:11])
//   lut_data  : U1.15 seed returned combinationally by the external LUT
//   busy      : unit is working on a request
//   recip     : U1.15 refined reciprocal, held between results
//   out_valid : one-cycle completion strobe
//   err       : input-fault flag, qualified by out_valid and held with recip
//
// Modports: master = requester / LUT owner, slave = newton_recip.
// ---------------------------------------------------------------------------
interface newton_recip_if;
   logic        start;
   logic [15:0] d_in;
   logic [3:0]  lut_idx;
   logic [15:0] lut_data;
   logic        busy;
   logic [15:0] recip;
   logic        out_valid;
   logic        err;

   modport master (
      output start, d_in, lut_data,
      input  lut_idx, busy, recip, out_valid, err
   );

   modport slave (
      input  start, d_in, lut_data,
      output lut_idx, busy, recip, out_valid, err
   );
endinterface

// File: rtl/newton_recip.sv
// ---------------------------------------------------------------------------
// newton_recip -- iterative Newton-Raphson reciprocal, U1.15 in / U1.15 out.
//
// A seed x0 ~ 1/d comes from an external combinational LUT indexed by
// d[14:11]; each iteration refines x <= x * (2 - d*x) using two multiply
// states. All arithmetic truncates.
//
// Parameters:
//   ITERS : number of Newton-Raphson iterations (1..3)
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : newton_recip_if.slave (start/d_in/lut_* request side,
//           busy/recip/out_valid/err result side)
// Optional feature:
//   RECIP_NORM_CHK_EN : when defined, a captured divisor with d[15]=0 skips
//                       iteration and completes with recip=0, err=1.
//                       When undefined, err is constant 0.
// ---------------------------------------------------------------------------
module newton_recip #(
   parameter int unsigned ITERS = 2
) (
   input  logic          clk,
   input  logic          reset,
   newton_recip_if.slave bus
);

   typedef enum logic [2:0] {IDLE, SEED, MUL1, MUL2, DONE} state_e;

   localparam logic [1:0] K_LAST = 2'(ITERS - 1);

   state_e      state_q, state_d;
   logic [15:0] d_q, d_d;
   logic [15:0] x_q, x_d;
   logic [31:0] e_q, e_d;
   logic [1:0]  k_q, k_d;
   logic [15:0] recip_q, recip_d;
   logic        out_valid_q, out_valid_d;
`ifdef RECIP_NORM_CHK_EN
   logic        err_q, err_d;
`endif

   logic [31:0] p;      // d*x, U2.30
   logic [17:0] q_hi;   // (x*e) >> 30: [17:16] overflow bits, [15:0] new x

   assign p    = 32'(d_q) * 32'(x_q);
   assign q_hi = 18'((48'(x_q) * 48'(e_q)) >> 30);

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         d_q         <= '0;
         x_q         <= '0;
         e_q         <= '0;
         k_q         <= '0;
         recip_q     <= '0;
         out_valid_q <= 1'b0;
`ifdef RECIP_NORM_CHK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         d_q         <= d_d;
         x_q         <= x_d;
         e_q         <= e_d;
         k_q         <= k_d;
         recip_q     <= recip_d;
         out_valid_q <= out_valid_d;
`ifdef RECIP_NORM_CHK_EN
         err_q       <= err_d;
`endif
      end
   end

   // Next-state and datapath next values
   always_comb begin
      state_d     = state_q;
      d_d         = d_q;
      x_d         = x_q;
      e_d         = e_q;
      k_d         = k_q;
      recip_d     = recip_q;
      out_valid_d = 1'b0;
`ifdef RECIP_NORM_CHK_EN
      err_d       = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               d_d     = bus.d_in;
               k_d     = '0;
               state_d = SEED;
            end
         end
         SEED: begin
            x_d     = bus.lut_data;
            state_d = MUL1;
`ifdef RECIP_NORM_CHK_EN
            if (!d_q[15]) begin
               x_d     = '0;
               state_d = DONE;
            end
`endif
         end
         MUL1: begin
            // 2^31 in U2.30 is 2.0; wraps modulo 2^32 like the register
            e_d     = 32'h8000_0000 - p;
            state_d = MUL2;
         end
         MUL2: begin
            x_d     = (q_hi[17:16] != 2'b00) ? '1 : q_hi[15:0];
            k_d     = k_q + 2'd1;
            state_d = (k_q == K_LAST) ? DONE : MUL1;
         end
         DONE: begin
            recip_d     = x_q;
            out_valid_d = 1'b1;
`ifdef RECIP_NORM_CHK_EN
            err_d       = ~d_q[15];
`endif
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.busy      = (state_q != IDLE);
      bus.lut_idx   = d_q[14:11];
      bus.recip     = recip_q;
      bus.out_valid = out_valid_q;
`ifdef RECIP_NORM_CHK_EN
      bus.err       = err_q;
`else
      bus.err       = 1'b0;
`endif
   end

endmodule
